// File: rtl/iref_ctrl.sv
// iref_ctrl: power-up sequencer and sharing controller for the RF current
// reference. Merges consumer requests, steps the IREF through
// power-down -> fast charge -> settle -> ready, and grants the consumers
// once the reference is usable. A minimum off time is enforced after every
// power-down before the next power-up may start.
module iref_ctrl #(
  parameter int N_REQ           = 3,
  parameter int CHARGE_CYCLES   = 16,
  parameter int SETTLE_CYCLES   = 8,
  parameter int OFF_HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             force_off,
  output logic             iref_pd,
  output logic             iref_charge,
  output logic             ready,
  output logic [N_REQ-1:0] gnt,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_CHARGE = 3'd1,
    ST_SETTLE = 3'd2,
    ST_READY  = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  // Counter reload values; each phase lasts (load + 1) cycles.
  localparam logic [15:0] CHARGE_LOAD = 16'(CHARGE_CYCLES - 1);
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] HOLD_LOAD   = 16'(OFF_HOLD_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [15:0]      cnt_reg, cnt_next;
  logic             pd_reg, pd_next;
  logic             charge_reg, charge_next;
  logic             ready_reg, ready_next;
  logic [N_REQ-1:0] gnt_reg, gnt_next;
  logic             want;

  // Any consumer asking for the reference, unless software forces it off.
  assign want = (|req) & ~force_off;

  // State, counter and all outputs are registered; reset is the OFF state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_OFF;
      cnt_reg    <= '0;
      pd_reg     <= 1'b1;
      charge_reg <= 1'b1;
      ready_reg  <= 1'b0;
      gnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      pd_reg     <= pd_next;
      charge_reg <= charge_next;
      ready_reg  <= ready_next;
      gnt_reg    <= gnt_next;
    end
  end

  // Next-state logic; a dropped request always wins over counter expiry.
  always_comb begin
    state_next = state_reg;
    // Counter saturates at zero instead of wrapping.
    cnt_next   = (cnt_reg != 16'd0) ? cnt_reg - 16'd1 : cnt_reg;
    case (state_reg)
      ST_OFF: begin
        if (want) begin
          state_next = ST_CHARGE;
          cnt_next   = CHARGE_LOAD;
        end
      end
      ST_CHARGE: begin
        if (!want) begin
          state_next = ST_HOLD;
          cnt_next   = HOLD_LOAD;
        end else if (cnt_reg == 16'd0) begin
          state_next = ST_SETTLE;
          cnt_next   = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (!want) begin
          state_next = ST_HOLD;
          cnt_next   = HOLD_LOAD;
        end else if (cnt_reg == 16'd0) begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        if (!want) begin
          state_next = ST_HOLD;
          cnt_next   = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        // Requests arriving here wait; the off time is never shortened.
        if (cnt_reg == 16'd0) begin
          state_next = ST_OFF;
        end
      end
      default: begin
        state_next = ST_OFF;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode from the next state so registered outputs track the state.
  always_comb begin
    pd_next     = 1'b1;
    charge_next = 1'b1;
    ready_next  = 1'b0;
    case (state_next)
      ST_CHARGE: begin
        pd_next = 1'b0;
      end
      ST_SETTLE: begin
        pd_next     = 1'b0;
        charge_next = 1'b0;
      end
      ST_READY: begin
        pd_next     = 1'b0;
        charge_next = 1'b0;
        ready_next  = 1'b1;
      end
      default: begin
        pd_next     = 1'b1;
        charge_next = 1'b1;
      end
    endcase
  end

  // Per-requester grant: only requesters that are currently asking.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_gnt
    assign gnt_next[gi] = req[gi] & ready_next;
  end

  assign iref_pd     = pd_reg;
  assign iref_charge = charge_reg;
  assign ready       = ready_reg;
  assign gnt         = gnt_reg;
  assign state       = state_reg;

endmodule

// File: tb/tb_iref_ctrl.sv
// Scoreboard bench for iref_ctrl: stimulus pushes the expected post-edge
// outputs, monitors pop and compare one entry per clock.
module tb_iref_ctrl;

  logic       clk;
  logic       rst_na, rst_nb;
  logic [2:0] req_a, req_b;
  logic       force_a, force_b;
  logic       pd_a, ch_a, rdy_a, pd_b, ch_b, rdy_b;
  logic [2:0] gnt_a, gnt_b, st_a, st_b;

  typedef struct {
    logic [8:0] v;
    string      tag;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0;
  int   bad   = 0;

  iref_ctrl dut_a (
    .clk(clk), .rst_n(rst_na), .req(req_a), .force_off(force_a),
    .iref_pd(pd_a), .iref_charge(ch_a), .ready(rdy_a), .gnt(gnt_a), .state(st_a)
  );

  iref_ctrl #(.N_REQ(3), .CHARGE_CYCLES(1), .SETTLE_CYCLES(1), .OFF_HOLD_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_nb), .req(req_b), .force_off(force_b),
    .iref_pd(pd_b), .iref_charge(ch_b), .ready(rdy_b), .gnt(gnt_b), .state(st_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected output word {state, pd, charge, ready, gnt} from the state table.
  function automatic logic [8:0] pack_exp(input logic [2:0] st, input logic [2:0] g);
    logic pd, ch, rd;
    case (st)
      3'd1:    begin pd = 1'b0; ch = 1'b1; rd = 1'b0; end
      3'd2:    begin pd = 1'b0; ch = 1'b0; rd = 1'b0; end
      3'd3:    begin pd = 1'b0; ch = 1'b0; rd = 1'b1; end
      default: begin pd = 1'b1; ch = 1'b1; rd = 1'b0; end
    endcase
    return {st, pd, ch, rd, g};
  endfunction

  task automatic compare(input string tag, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got st=%0d pd=%b ch=%b rdy=%b gnt=%b, expected st=%0d pd=%b ch=%b rdy=%b gnt=%b",
               tag, act[8:6], act[5], act[4], act[3], act[2:0], exp[8:6], exp[5], exp[4], exp[3], exp[2:0]);
    end else begin
      $display("ok   %s: st=%0d pd=%b ch=%b rdy=%b gnt=%b", tag, act[8:6], act[5], act[4], act[3], act[2:0]);
    end
  endtask

  // Immediate (non-clocked) check, used for asynchronous reset.
  task automatic chk_now(input int d, input logic [2:0] st, input logic [2:0] g, input string tag);
    if (d == 0) compare(tag, {st_a, pd_a, ch_a, rdy_a, gnt_a}, pack_exp(st, g));
    else        compare(tag, {st_b, pd_b, ch_b, rdy_b, gnt_b}, pack_exp(st, g));
  endtask

  // Push the expected outputs after the coming edge, then pass that edge.
  task automatic step(input int d, input logic [2:0] st, input logic [2:0] g, input string tag);
    exp_t e;
    e.v   = pack_exp(st, g);
    e.tag = tag;
    if (d == 0) qa.push_back(e);
    else        qb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Power-up timeline: edge 0 is the edge where pd falls.
  task automatic run_seq(input int d, input int c, input int s, input logic [2:0] r,
                         input int first, input int last, input string tag);
    logic [2:0] st;
    for (int e = first; e <= last; e++) begin
      if (e < c)          st = 3'd1;
      else if (e < c + s) st = 3'd2;
      else                st = 3'd3;
      step(d, st, (st == 3'd3) ? r : 3'b000, $sformatf("%s e%0d", tag, e));
    end
  endtask

  // Power-down timeline: edge 0 enters HOLD, edge h returns to OFF.
  task automatic hold_seq(input int d, input int h, input int first, input string tag);
    for (int k = first; k <= h; k++) begin
      step(d, (k < h) ? 3'd4 : 3'd0, 3'b000, $sformatf("%s h%0d", tag, k));
    end
  endtask

  initial begin : mon_a
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        compare({"A ", e.tag}, {st_a, pd_a, ch_a, rdy_a, gnt_a}, e.v);
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qb.size() > 0) begin
        e = qb.pop_front();
        compare({"B ", e.tag}, {st_b, pd_b, ch_b, rdy_b, gnt_b}, e.v);
      end
    end
  end

  initial begin : stim
    rst_na = 1'b1; rst_nb = 1'b1;
    req_a = 3'b000; req_b = 3'b000;
    force_a = 1'b0; force_b = 1'b0;
    #1;
    rst_na = 1'b0; rst_nb = 1'b0;
    #1;
    chk_now(0, 3'd0, 3'b000, "A reset");
    chk_now(1, 3'd0, 3'b000, "B reset");
    #11;
    rst_na = 1'b1; rst_nb = 1'b1;
    @(posedge clk);
    #2;
    step(0, 3'd0, 3'b000, "t1 idle");

    // Single requester, stopped partway into SETTLE.
    req_a = 3'b001;
    run_seq(0, 16, 8, 3'b001, 0, 18, "t1");

    // Asynchronous reset in SETTLE, then a full restart.
    #1;
    rst_na = 1'b0;
    #1;
    chk_now(0, 3'd0, 3'b000, "t2 async reset");
    #2;
    rst_na = 1'b1;
    run_seq(0, 16, 8, 3'b001, 0, 24, "t2");

    // Drop from READY, then abort in CHARGE with immediate re-request.
    req_a = 3'b000;
    hold_seq(0, 4, 0, "t3 drop");
    req_a = 3'b001;
    run_seq(0, 16, 8, 3'b001, 0, 5, "t3 charge");
    req_a = 3'b000;
    step(0, 3'd4, 3'b000, "t3 abort h0");
    req_a = 3'b001;
    hold_seq(0, 4, 1, "t3 rereq");
    run_seq(0, 16, 8, 3'b001, 0, 24, "t3 restart");

    // Sharing while READY.
    req_a = 3'b011;
    for (int i = 0; i < 3; i++) step(0, 3'd3, 3'b011, $sformatf("t4 join %0d", i));
    req_a = 3'b010;
    for (int i = 0; i < 3; i++) step(0, 3'd3, 3'b010, $sformatf("t4 leave %0d", i));

    // Software override for 10 edges, then a fresh sequence.
    force_a = 1'b1;
    hold_seq(0, 4, 0, "t5 force");
    for (int k = 5; k < 10; k++) step(0, 3'd0, 3'b000, $sformatf("t5 force h%0d", k));
    force_a = 1'b0;
    run_seq(0, 16, 8, 3'b010, 0, 24, "t5 resume");

    // Minimum parameters on the second instance.
    req_b = 3'b001;
    run_seq(1, 1, 1, 3'b001, 0, 3, "t6");
    req_b = 3'b000;
    hold_seq(1, 1, 0, "t6 drop");
    req_b = 3'b100;
    run_seq(1, 1, 1, 3'b100, 0, 2, "t6 again");

    repeat (2) @(posedge clk);
    #2;
    if (qa.size() != 0 || qb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: entries left a=%0d b=%0d, expected 0", qa.size(), qb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iref_ctrl.md
Name: iref_ctrl

Overview:
- Power-up sequencer and sharing controller for the RF current-reference generator (IREF).
- Collects enable requests from several RF consumers (e.g. LNA, LO, PA) and drives the IREF `pd` and `charge` controls in the required order.
- Tells the consumers when the reference current is settled and usable.
- Sits in the RF front-end control logic between the consumer control FSMs and the IREF analog macro.

Parameters:
- N_REQ, 3, number of requesters sharing the IREF.
- CHARGE_CYCLES, 16, cycles `charge` stays high after `pd` falls (range 1..65535).
- SETTLE_CYCLES, 8, cycles after `charge` falls before the reference is declared ready (range 1..65535).
- OFF_HOLD_CYCLES, 4, minimum cycles `pd` stays high after a power-down before a new power-up (range 1..65535).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester IREF enable request, level-sensitive.
- force_off  in  1  software override; when high, the IREF is powered down regardless of `req`.
- iref_pd  out  1  IREF power-down control (1 = powered down).
- iref_charge  out  1  IREF fast-charge control (1 = charging).
- ready  out  1  reference current settled.
- gnt  out  N_REQ  per-requester grant, equal to `req & {N_REQ{ready}}`, registered.
- state  out  3  current FSM state encoding, for status/debug.

Behaviour:
- Reset values (asynchronous, on `rst_n` low): state = OFF; `iref_pd` = 1; `iref_charge` = 1; `ready` = 0; `gnt` = 0; counter = 0.
- All outputs are registered and change only on a `clk` rising edge, except during asynchronous reset.
- Internal signal: `want = |req & ~force_off`.
- State encoding: OFF = 0, CHARGE = 1, SETTLE = 2, READY = 3, HOLD = 4.
- OFF:
  - Outputs: `pd` = 1, `charge` = 1, `ready` = 0.
  - On an edge where `want` = 1: go to CHARGE, load counter with CHARGE_CYCLES-1.
- CHARGE:
  - Outputs: `pd` = 0, `charge` = 1.
  - Counter decrements each cycle.
  - When counter = 0 and `want` = 1: go to SETTLE, load counter with SETTLE_CYCLES-1.
  - CHARGE lasts exactly CHARGE_CYCLES cycles.
- SETTLE:
  - Outputs: `pd` = 0, `charge` = 0.
  - When counter = 0 and `want` = 1: go to READY.
  - SETTLE lasts exactly SETTLE_CYCLES cycles.
- READY:
  - Outputs: `pd` = 0, `charge` = 0, `ready` = 1.
  - Stays in READY while `want` = 1.
- HOLD:
  - Outputs: `pd` = 1, `charge` = 1, `ready` = 0.
  - Entered with counter loaded to OFF_HOLD_CYCLES-1; decrements each cycle.
  - When counter = 0: go to OFF. A pending `want` is then honoured from OFF on the next edge.
- Abort and power-down:
  - In CHARGE, SETTLE or READY, `want` = 0 on any edge sends the FSM to HOLD immediately. This takes priority over counter expiry.
  - `want` returning high during HOLD does not shorten HOLD.
- Latency:
  - `pd` falls on the first edge that samples `want` = 1 in OFF.
  - `charge` falls CHARGE_CYCLES edges later.
  - `ready` rises CHARGE_CYCLES + SETTLE_CYCLES edges after `pd` falls.
  - `ready` falls on the first edge that samples `want` = 0.
- Grants and sharing:
  - `gnt` is registered from the next-state `ready` and the current `req`.
  - A requester joining while READY gets `gnt` on the next edge with no re-sequencing.
  - One requester leaving while others remain has no effect on the IREF.
- `force_off` has the same effect as all requests low.
- Counter width is 16 bits; the counter does not wrap, it is only decremented while non-zero.

Test Plan:
- Defaults, single requester: reset, then `req`=3'b001 → `pd` falls on edge 0; `charge` falls at edge 16; `ready` and `gnt`[0] rise at edge 24.
- Reset mid-sequence: `rst_n` low during SETTLE → `pd`=1, `charge`=1, `ready`=0 immediately (asynchronously); after release with `req` still high, the full 24-cycle sequence restarts.
- Abort during CHARGE: `req` drops at CHARGE cycle 5 → HOLD next edge with `pd`=1, `charge`=1; re-raising `req` immediately → `pd` falls no earlier than 5 edges after entering HOLD (4 in HOLD, 1 in OFF).
- Sharing: `req`=001 until READY, then `req`=011, then `req`=010 → `gnt` goes 001, 011, 010; `ready` and `pd` never toggle.
- Override: in READY, assert `force_off` → `ready`=0 and `gnt`=0 on the next edge, `pd`=1; deassert after 10 cycles with `req` high → new sequence, `ready` 24 edges after `pd` falls.
- Minimum parameters: CHARGE_CYCLES = SETTLE_CYCLES = OFF_HOLD_CYCLES = 1 → `charge` falls 1 edge and `ready` rises 2 edges after `pd` falls; HOLD lasts 1 cycle.
